xm_mc_sequencer: RTL and testbench
==================================

Name: xm_mc_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the XM core: fetch / decode / execute / memory / exception.
- Drives datapath strobes and a request/acknowledge memory handshake with programmable timeout.
- Adds interrupt and exception entry plus a double-fault halt.
- Sits between the instruction decoder, register file/ALU/PSW datapath and the memory port.

Parameters:
WORD, 16, datapath width
LR, 5, link register index
SP, 6, stack pointer index
TMO_W, 4, timeout counter width
MEM_TIMEOUT, 15, max wait cycles per request before bus error (1..2^TMO_W-1)
VEC_BASE, 16'hFFC0, exception vector table base; vector = VEC_BASE + 2*cause

Ports:
clk_i in 1 clock, rising edge
arst_i in 1 reset; synchronous, active-high
memAck_i in 1 memory transfer complete this cycle
memErr_i in 1 bus error, qualified by memAck_i
irq_i in 1 level interrupt request
irqEn_i in 1 PSW interrupt enable
instClass_i in 3 decoded class: 0 ALU, 1 COND_BR, 2 LINK_BR, 3 LOAD, 4 STORE, 5 TRAP, 6-7 illegal
branchRes_i in 1 condition result
byteOp_i in 1 byte access
regAdrA_i, regAdrB_i in 3 each, decoded register addresses
memReq_o out 1 memory request
memWr_o out 1 1 = write
memByte_o out 1 byte transfer
memAdrSel_o out 2 address source: 0 PC, 1 ALU, 2 SP-2, 3 vector
memDatSel_o out 2 write data source: 0 regB, 1 PSW, 2 PC
irWr_o, pcWr_o, regWr_o, flagsWr_o, spDec_o, clrIrqEn_o out 1 each, datapath strobes
pcSel_o out 2 PC source: 0 PC+2, 1 branch target, 2 memory data
regWrAdr_o out 3 register file write address
regWrSrc_o out 2 register write source: 0 ALU, 1 memory, 2 PC
excCause_o out 2 latched cause: 0 IRQ, 1 bus error, 2 illegal, 3 trap
halted_o out 1 double-fault halt
state_o out 4 current state, debug

Behaviour:
- State register and all counters update on rising clk_i.
- Outputs are combinational from state. memReq_o-qualified strobes are Mealy on memAck_i.
- Reset, synchronous: state <= FETCH; tmo <= 0; excCause_o <= 0; halted_o <= 0. All strobes and memReq_o are 0 while arst_i is high.
- Reset mid-transfer drops memReq_o the next cycle. No completion strobe is issued.
- Handshake:
  - memReq_o is held high with memWr_o, memByte_o, memAdrSel_o and memDatSel_o stable until the cycle memAck_i=1.
  - Same-cycle ack is allowed (zero-wait); a zero-wait access costs 1 cycle.
  - tmo increments each cycle memReq_o=1 and memAck_i=0. tmo clears on ack or on leaving a memory state.
  - When tmo == MEM_TIMEOUT and there is no ack, the request is aborted: memReq_o=0 the next cycle and a bus error is raised.
  - memAck_i & memErr_i is treated as a bus error. The data-side strobe (irWr_o / regWr_o / pcWr_o) is suppressed.
- States:
  - FETCH:
    - irq_i & irqEn_i -> EXC_PSW, cause 0.
    - Otherwise: memReq_o, adr 0. On ack: irWr_o, pcWr_o with pcSel 0 -> DECODE.
  - DECODE: one cycle -> class state. Classes 6-7 -> EXC_PSW, cause 2.
  - ALU: regWr_o, flagsWr_o, regWrSrc 0 -> FETCH.
  - COND_BR: pcSel 1; pcWr_o = branchRes_i -> FETCH.
  - LINK_BR: pcWr_o with pcSel 1; regWr_o with regWrAdr LR, src 2; same cycle -> FETCH.
  - LOAD: memReq_o, adr 1, byte = byteOp_i. On ack: regWr_o with regWrAdr regAdrA_i, src 1 -> FETCH.
  - STORE: memReq_o, memWr_o, adr 1, dat 0. On ack -> FETCH.
  - TRAP: -> EXC_PSW, cause 3.
  - EXC_PSW: write, adr 2, dat 1. On ack: spDec_o, clrIrqEn_o -> EXC_PC.
  - EXC_PC: write, adr 2, dat 2. On ack: spDec_o -> EXC_VEC.
  - EXC_VEC: read, adr 3. On ack: pcWr_o with pcSel 2 -> FETCH.
  - HALT: no strobes; halted_o=1. Exit only by reset.
- Bus error in FETCH, LOAD or STORE -> EXC_PSW, cause 1.
- Bus error in EXC_* -> HALT (double fault).
- excCause_o is latched on entry to EXC_PSW and held until the next entry.
- IRQ is sampled only in FETCH before the request is issued. An IRQ arriving during execute is serviced at the next FETCH.
- Word accesses force memByte_o=0.

Test Plan:
1. Reset, then zero-wait fetch of ALU class (memAck_i tied 1) -> FETCH, DECODE, ALU: 3 cycles, 1 irWr_o, 1 pcWr_o, 1 regWr_o + flagsWr_o.
2. LOAD with ack after 3 wait cycles, regAdrA_i=3, byteOp_i=1 -> memReq_o high 4 cycles, memByte_o=1, addresses stable, regWr_o exactly in the ack cycle with regWrAdr_o=3.
3. No ack on fetch, MEM_TIMEOUT=15 -> memReq_o high 16 cycles, then EXC_PSW, excCause_o=1; vector read address select 3 (vector 16'hFFC2).
4. irq_i=1, irqEn_i=1 at FETCH -> exactly 2 spDec_o pulses, then pcWr_o with pcSel_o=2, excCause_o=0. With irqEn_i=0 -> normal fetch.
5. instClass_i=6 -> excCause_o=2. memErr_i on the EXC_PC ack -> HALT, halted_o=1 until arst_i; after reset, FETCH with halted_o=0.
6. LINK_BR -> pcWr_o and regWr_o in the same cycle, regWrAdr_o=5, regWrSrc_o=2; COND_BR with branchRes_i=0 -> no pcWr_o.

Source files
------------

// File: rtl/xm_mc_sequencer.sv
// xm_mc_sequencer: multi-cycle control sequencer for the XM core.
// Walks fetch / decode / execute / memory / exception, drives datapath
// strobes and a req/ack memory handshake with a per-request timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | instruction read at PC (or IRQ entry when enabled)
// DECODE    | one-cycle dispatch on instClass_i
// ALU       | write ALU result and flags
// COND_BR   | conditional PC load from branch target
// LINK_BR   | PC load from branch target, old PC into LR
// LOAD      | data read at ALU address into regAdrA_i
// STORE     | data write of regB at ALU address
// TRAP      | software trap, enters exception sequence
// EXC_PSW   | push PSW at SP-2, clear interrupt enable
// EXC_PC    | push PC at SP-2
// EXC_VEC   | read handler address from vector table into PC
// HALT      | double fault, only reset leaves
module xm_mc_sequencer #(
  parameter int          WORD        = 16,
  parameter int          LR          = 5,
  parameter int          SP          = 6,
  parameter int          TMO_W       = 4,
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [15:0] VEC_BASE    = 16'hFFC0
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       memAck_i,
  input  logic       memErr_i,
  input  logic       irq_i,
  input  logic       irqEn_i,
  input  logic [2:0] instClass_i,
  input  logic       branchRes_i,
  input  logic       byteOp_i,
  input  logic [2:0] regAdrA_i,
  input  logic [2:0] regAdrB_i,
  output logic       memReq_o,
  output logic       memWr_o,
  output logic       memByte_o,
  output logic [1:0] memAdrSel_o,
  output logic [1:0] memDatSel_o,
  output logic       irWr_o,
  output logic       pcWr_o,
  output logic       regWr_o,
  output logic       flagsWr_o,
  output logic       spDec_o,
  output logic       clrIrqEn_o,
  output logic [1:0] pcSel_o,
  output logic [2:0] regWrAdr_o,
  output logic [1:0] regWrSrc_o,
  output logic [1:0] excCause_o,
  output logic       halted_o,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_ALU     = 4'd2;
  localparam logic [3:0] S_CBR     = 4'd3;
  localparam logic [3:0] S_LBR     = 4'd4;
  localparam logic [3:0] S_LOAD    = 4'd5;
  localparam logic [3:0] S_STORE   = 4'd6;
  localparam logic [3:0] S_TRAP    = 4'd7;
  localparam logic [3:0] S_EXC_PSW = 4'd8;
  localparam logic [3:0] S_EXC_PC  = 4'd9;
  localparam logic [3:0] S_EXC_VEC = 4'd10;
  localparam logic [3:0] S_HALT    = 4'd11;

  localparam logic [1:0] C_IRQ   = 2'd0;
  localparam logic [1:0] C_BUS   = 2'd1;
  localparam logic [1:0] C_ILL   = 2'd2;
  localparam logic [1:0] C_TRAP  = 2'd3;

  logic [3:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cause_q, cause_d;
  logic             halted_q;
  logic             abort_q;

  logic       irq_take;
  logic       mem_st, acc_wr, acc_byte;
  logic [1:0] adr_sel, dat_sel;
  logic       req, ack_ok, tmo_hit, bus_err;

  logic       ir_wr, pc_wr, reg_wr, flags_wr, sp_dec, clr_ie;
  logic [1:0] pc_sel, reg_src;
  logic [2:0] reg_adr;

  // IRQ is only considered before the fetch request goes out, never mid-wait.
  assign irq_take = (state_q == S_FETCH) && irq_i && irqEn_i && (tmo_q == '0);

  // Memory access attributes per state; held constant for the whole request.
  always_comb begin
    mem_st   = 1'b0;
    acc_wr   = 1'b0;
    acc_byte = 1'b0;
    adr_sel  = 2'd0;
    dat_sel  = 2'd0;
    case (state_q)
      S_FETCH:   begin mem_st = !irq_take; adr_sel = 2'd0; end
      S_LOAD:    begin mem_st = 1'b1; adr_sel = 2'd1; acc_byte = byteOp_i; end
      S_STORE:   begin mem_st = 1'b1; acc_wr = 1'b1; adr_sel = 2'd1; dat_sel = 2'd0;
                       acc_byte = byteOp_i; end
      S_EXC_PSW: begin mem_st = 1'b1; acc_wr = 1'b1; adr_sel = 2'd2; dat_sel = 2'd1; end
      S_EXC_PC:  begin mem_st = 1'b1; acc_wr = 1'b1; adr_sel = 2'd2; dat_sel = 2'd2; end
      S_EXC_VEC: begin mem_st = 1'b1; adr_sel = 2'd3; end
      default:   ;
    endcase
  end

  // The cycle after a timeout abort keeps the request low even if the next
  // state is itself a memory state, so the aborted transfer is visibly dropped.
  assign req     = mem_st && !abort_q;
  assign tmo_hit = req && !memAck_i && (tmo_q == TMO_W'(MEM_TIMEOUT));
  assign bus_err = (req && memAck_i && memErr_i) || tmo_hit;
  assign ack_ok  = req && memAck_i && !memErr_i;
  assign tmo_d   = (req && !memAck_i && !tmo_hit) ? tmo_q + TMO_W'(1) : '0;

  // Next-state, exception cause and Mealy datapath strobes.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    reg_wr   = 1'b0;
    flags_wr = 1'b0;
    sp_dec   = 1'b0;
    clr_ie   = 1'b0;
    pc_sel   = 2'd0;
    reg_adr  = regAdrA_i;
    reg_src  = 2'd0;
    case (state_q)
      S_FETCH: begin
        if (irq_take) begin
          state_d = S_EXC_PSW;
          cause_d = C_IRQ;
        end else if (ack_ok) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          pc_sel  = 2'd0;
          state_d = S_DECODE;
        end else if (bus_err) begin
          state_d = S_EXC_PSW;
          cause_d = C_BUS;
        end
      end
      S_DECODE: begin
        case (instClass_i)
          3'd0:    state_d = S_ALU;
          3'd1:    state_d = S_CBR;
          3'd2:    state_d = S_LBR;
          3'd3:    state_d = S_LOAD;
          3'd4:    state_d = S_STORE;
          3'd5:    state_d = S_TRAP;
          default: begin state_d = S_EXC_PSW; cause_d = C_ILL; end
        endcase
      end
      S_ALU: begin
        reg_wr   = 1'b1;
        flags_wr = 1'b1;
        reg_src  = 2'd0;
        state_d  = S_FETCH;
      end
      S_CBR: begin
        pc_sel  = 2'd1;
        pc_wr   = branchRes_i;
        state_d = S_FETCH;
      end
      S_LBR: begin
        pc_wr   = 1'b1;
        pc_sel  = 2'd1;
        reg_wr  = 1'b1;
        reg_adr = 3'(LR);
        reg_src = 2'd2;
        state_d = S_FETCH;
      end
      S_LOAD: begin
        if (ack_ok) begin
          reg_wr  = 1'b1;
          reg_src = 2'd1;
          state_d = S_FETCH;
        end else if (bus_err) begin
          state_d = S_EXC_PSW;
          cause_d = C_BUS;
        end
      end
      S_STORE: begin
        if (ack_ok) begin
          state_d = S_FETCH;
        end else if (bus_err) begin
          state_d = S_EXC_PSW;
          cause_d = C_BUS;
        end
      end
      S_TRAP: begin
        state_d = S_EXC_PSW;
        cause_d = C_TRAP;
      end
      S_EXC_PSW: begin
        if (ack_ok) begin
          sp_dec  = 1'b1;
          clr_ie  = 1'b1;
          state_d = S_EXC_PC;
        end else if (bus_err) begin
          state_d = S_HALT;
        end
      end
      S_EXC_PC: begin
        if (ack_ok) begin
          sp_dec  = 1'b1;
          state_d = S_EXC_VEC;
        end else if (bus_err) begin
          state_d = S_HALT;
        end
      end
      S_EXC_VEC: begin
        if (ack_ok) begin
          pc_wr   = 1'b1;
          pc_sel  = 2'd2;
          state_d = S_FETCH;
        end else if (bus_err) begin
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, timeout counter, abort flag, latched cause and halt flag.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q  <= S_FETCH;
      tmo_q    <= '0;
      cause_q  <= C_IRQ;
      halted_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      cause_q  <= cause_d;
      halted_q <= (state_d == S_HALT);
      abort_q  <= tmo_hit;
    end
  end

  assign memReq_o    = req & ~arst_i;
  assign memWr_o     = req & acc_wr & ~arst_i;
  assign memByte_o   = req & acc_byte & ~arst_i;
  assign memAdrSel_o = adr_sel;
  assign memDatSel_o = dat_sel;
  assign irWr_o      = ir_wr & ~arst_i;
  assign pcWr_o      = pc_wr & ~arst_i;
  assign regWr_o     = reg_wr & ~arst_i;
  assign flagsWr_o   = flags_wr & ~arst_i;
  assign spDec_o     = sp_dec & ~arst_i;
  assign clrIrqEn_o  = clr_ie & ~arst_i;
  assign pcSel_o     = pc_sel;
  assign regWrAdr_o  = reg_adr;
  assign regWrSrc_o  = reg_src;
  assign excCause_o  = cause_q;
  assign halted_o    = halted_q;
  assign state_o     = state_q;

  // Datapath width, SP index, vector base and port B address live in the
  // datapath; the sequencer only selects sources.
  logic unused_ok;
  assign unused_ok = (^{regAdrB_i, VEC_BASE}) ^ (WORD != 0) ^ (SP != 0);

endmodule

// File: tb/tb_xm_mc_sequencer.sv
// Bench for xm_mc_sequencer: directed and random instructions against a
// per-instruction cost/strobe model.
module tb_xm_mc_sequencer;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       arst_i = 1'b1;
  logic       memAck_i = 1'b0, memErr_i = 1'b0, irq_i = 1'b0, irqEn_i = 1'b0;
  logic [2:0] instClass_i = '0, regAdrA_i = '0, regAdrB_i = '0;
  logic       branchRes_i = 1'b0, byteOp_i = 1'b0;
  logic       memReq_o, memWr_o, memByte_o;
  logic [1:0] memAdrSel_o, memDatSel_o, pcSel_o, regWrSrc_o, excCause_o;
  logic       irWr_o, pcWr_o, regWr_o, flagsWr_o, spDec_o, clrIrqEn_o, halted_o;
  logic [2:0] regWrAdr_o;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  xm_mc_sequencer dut (
    .clk_i(clk), .arst_i(arst_i), .memAck_i(memAck_i), .memErr_i(memErr_i),
    .irq_i(irq_i), .irqEn_i(irqEn_i), .instClass_i(instClass_i),
    .branchRes_i(branchRes_i), .byteOp_i(byteOp_i), .regAdrA_i(regAdrA_i),
    .regAdrB_i(regAdrB_i), .memReq_o(memReq_o), .memWr_o(memWr_o),
    .memByte_o(memByte_o), .memAdrSel_o(memAdrSel_o), .memDatSel_o(memDatSel_o),
    .irWr_o(irWr_o), .pcWr_o(pcWr_o), .regWr_o(regWr_o), .flagsWr_o(flagsWr_o),
    .spDec_o(spDec_o), .clrIrqEn_o(clrIrqEn_o), .pcSel_o(pcSel_o),
    .regWrAdr_o(regWrAdr_o), .regWrSrc_o(regWrSrc_o), .excCause_o(excCause_o),
    .halted_o(halted_o), .state_o(state_o)
  );

  int vectors = 0, miscompares = 0;

  // memory responder: wait cycles per access index, one access may error
  int wait_tab[8];
  int err_idx = -1;
  int a_idx, req_cnt;
  bit held;
  logic [5:0] held_sig;

  // observed activity over one instruction
  int c_ir, c_pc, c_rw, c_fl, c_sp, c_clr, c_byte, c_wr, c_dat1, c_dat2, c_stab;
  int c_adr[4];
  logic [1:0] last_pcsel, last_rwsrc;
  logic [2:0] last_rwadr;

  // expected activity from the model
  int e_cyc, e_ir, e_pc, e_rw, e_fl, e_sp, e_clr, e_byte, e_wr, e_dat1, e_dat2;
  int e_pcsel, e_rwadr, e_rwsrc;
  int e_adr[4];
  bit e_halt, m_gap;
  int m_cause = 0, m_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    c_ir = 0; c_pc = 0; c_rw = 0; c_fl = 0; c_sp = 0; c_clr = 0;
    c_byte = 0; c_wr = 0; c_dat1 = 0; c_dat2 = 0; c_stab = 0;
    foreach (c_adr[k]) c_adr[k] = 0;
    last_pcsel = 0; last_rwsrc = 0; last_rwadr = 0;
  endtask

  // one clock: answer the request, sample mid-low-phase, advance to next negedge
  task automatic step();
    logic [5:0] sig;
    int w;
    w = (a_idx < 8) ? wait_tab[a_idx] : 0;
    if (memReq_o) begin
      memAck_i = (req_cnt >= w);
      memErr_i = memAck_i && (a_idx == err_idx);
    end else begin
      memAck_i = 1'b0;
      memErr_i = 1'b0;
    end
    #1;
    if (irWr_o) c_ir++;
    if (pcWr_o) begin c_pc++; last_pcsel = pcSel_o; end
    if (regWr_o) begin c_rw++; last_rwadr = regWrAdr_o; last_rwsrc = regWrSrc_o; end
    if (flagsWr_o) c_fl++;
    if (spDec_o) c_sp++;
    if (clrIrqEn_o) c_clr++;
    if (memReq_o) begin
      sig = {memWr_o, memByte_o, memAdrSel_o, memDatSel_o};
      c_adr[memAdrSel_o]++;
      if (memByte_o) c_byte++;
      if (memWr_o) begin
        c_wr++;
        if (memDatSel_o == 2'd1) c_dat1++;
        if (memDatSel_o == 2'd2) c_dat2++;
      end
      if (held && sig != held_sig) c_stab++;
      held = !memAck_i;
      held_sig = sig;
      if (memAck_i) begin a_idx++; req_cnt = 0; end
      else req_cnt++;
    end else begin
      held = 1'b0;
      if (req_cnt > 0) begin a_idx++; req_cnt = 0; end
    end
    @(negedge clk);
  endtask

  task automatic peek_fetch();
    logic sv;
    sv = irq_i; irq_i = 1'b0; memAck_i = 1'b0; memErr_i = 1'b0;
    #1;
    chk("fetch_start", {memReq_o, memWr_o, memAdrSel_o}, 4'b1000);
    irq_i = sv;
  endtask

  task automatic do_reset();
    arst_i = 1'b1; memAck_i = 1'b1; memErr_i = 1'b0; irq_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_quiet", {memReq_o, irWr_o, pcWr_o, regWr_o, flagsWr_o, spDec_o, clrIrqEn_o}, 0);
      @(negedge clk);
    end
    arst_i = 1'b0; memAck_i = 1'b0;
    m_cause = 0; a_idx = 0; req_cnt = 0; held = 1'b0;
    peek_fetch();
    chk("rst_halted", halted_o, 0);
    chk("rst_cause", excCause_o, 0);
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 push PSW, 4 push PC, 5 vector read
  task automatic m_acc(input int kind, input bit byt, output bit ok);
    int cost;
    bit tmo;
    tmo  = wait_tab[m_a] > TMO;
    cost = tmo ? TMO + 1 : wait_tab[m_a] + 1;
    e_cyc += cost + (m_gap ? 1 : 0);
    m_gap = tmo;
    case (kind)
      0:       e_adr[0] += cost;
      1, 2:    begin e_adr[1] += cost; if (byt) e_byte += cost; end
      3, 4:    e_adr[2] += cost;
      default: e_adr[3] += cost;
    endcase
    if (kind == 2 || kind == 3 || kind == 4) e_wr += cost;
    if (kind == 3) e_dat1 += cost;
    if (kind == 4) e_dat2 += cost;
    ok = !tmo && (m_a != err_idx);
    m_a++;
  endtask

  task automatic run_instr(input int cls, input bit irq, input bit en, input bit br,
                           input bit byt, input logic [2:0] ra, input bit late);
    int exc;
    bit ok;
    e_cyc = 0; e_ir = 0; e_pc = 0; e_rw = 0; e_fl = 0; e_sp = 0; e_clr = 0;
    e_byte = 0; e_wr = 0; e_dat1 = 0; e_dat2 = 0; e_pcsel = 0; e_rwadr = 0; e_rwsrc = 0;
    foreach (e_adr[k]) e_adr[k] = 0;
    m_a = 0; m_gap = 0; exc = -1; e_halt = 0;
    if (irq && en) begin
      e_cyc += 1; exc = 0;
    end else begin
      m_acc(0, 0, ok);
      if (!ok) exc = 1;
      else begin
        e_ir++; e_pc++; e_pcsel = 0; e_cyc++;
        case (cls)
          0: begin e_cyc++; e_rw++; e_fl++; e_rwadr = ra; e_rwsrc = 0; end
          1: begin e_cyc++; if (br) begin e_pc++; e_pcsel = 1; end end
          2: begin e_cyc++; e_pc++; e_pcsel = 1; e_rw++; e_rwadr = 5; e_rwsrc = 2; end
          3: begin
            m_acc(1, byt, ok);
            if (ok) begin e_rw++; e_rwadr = ra; e_rwsrc = 1; end else exc = 1;
          end
          4: begin m_acc(2, byt, ok); if (!ok) exc = 1; end
          5: begin e_cyc++; exc = 3; end
          default: exc = 2;
        endcase
      end
    end
    if (exc >= 0) begin
      m_cause = exc;
      m_acc(3, 0, ok);
      if (ok) begin
        e_sp++; e_clr++;
        m_acc(4, 0, ok);
        if (ok) begin
          e_sp++;
          m_acc(5, 0, ok);
          if (ok) begin e_pc++; e_pcsel = 2; end
        end
      end
      e_halt = !ok;
    end

    instClass_i = 3'(cls); irq_i = irq; irqEn_i = en; branchRes_i = br;
    byteOp_i = byt; regAdrA_i = ra; regAdrB_i = ~ra;
    clr_cnt(); a_idx = 0; req_cnt = 0; held = 1'b0;
    for (int i = 0; i < e_cyc; i++) begin
      step();
      if (i == 0) irq_i = 1'b0;
      if (i == 1 && late) irq_i = 1'b1;
    end

    chk("irWr", c_ir, e_ir);
    chk("pcWr", c_pc, e_pc);
    chk("regWr", c_rw, e_rw);
    chk("flagsWr", c_fl, e_fl);
    chk("spDec", c_sp, e_sp);
    chk("clrIrqEn", c_clr, e_clr);
    chk("req_pc", c_adr[0], e_adr[0]);
    chk("req_alu", c_adr[1], e_adr[1]);
    chk("req_sp", c_adr[2], e_adr[2]);
    chk("req_vec", c_adr[3], e_adr[3]);
    chk("memByte", c_byte, e_byte);
    chk("memWr", c_wr, e_wr);
    chk("dat_psw", c_dat1, e_dat1);
    chk("dat_pc", c_dat2, e_dat2);
    chk("req_stable", c_stab, 0);
    if (e_pc > 0) chk("pcSel", last_pcsel, e_pcsel);
    if (e_rw > 0) begin
      chk("regWrAdr", last_rwadr, e_rwadr);
      chk("regWrSrc", last_rwsrc, e_rwsrc);
    end
    chk("excCause", excCause_o, m_cause);
    chk("halted", halted_o, e_halt);
    if (e_halt) begin
      clr_cnt();
      repeat (4) step();
      chk("halt_quiet", c_ir + c_pc + c_rw + c_fl + c_sp + c_clr + c_adr[0] + c_adr[1]
                        + c_adr[2] + c_adr[3], 0);
      chk("halt_hold", halted_o, 1);
      do_reset();
    end else begin
      peek_fetch();
    end
  endtask

  task automatic set_waits(input int w);
    foreach (wait_tab[k]) wait_tab[k] = w;
    err_idx = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    set_waits(0);
    run_instr(0, 0, 0, 0, 0, 3'd4, 0);          // zero-wait ALU
    set_waits(0); wait_tab[1] = 3;
    run_instr(3, 0, 0, 0, 1, 3'd3, 0);          // byte load, 3 waits
    set_waits(0); wait_tab[0] = 100;
    run_instr(0, 0, 0, 0, 0, 3'd1, 0);          // fetch timeout -> bus error
    set_waits(0); wait_tab[0] = TMO;
    run_instr(0, 0, 0, 0, 0, 3'd2, 0);          // ack on the last allowed cycle
    set_waits(1);
    run_instr(0, 1, 1, 0, 0, 3'd0, 0);          // IRQ entry
    set_waits(0);
    run_instr(0, 1, 0, 0, 0, 3'd6, 0);          // IRQ masked
    run_instr(0, 0, 1, 0, 0, 3'd7, 1);          // IRQ rises during execute
    run_instr(0, 1, 1, 0, 0, 3'd7, 0);          // ...taken at next fetch
    run_instr(6, 0, 0, 0, 0, 3'd0, 0);          // illegal
    set_waits(0); err_idx = 2;
    run_instr(7, 0, 0, 0, 0, 3'd0, 0);          // illegal, error on PC push -> halt
    set_waits(0);
    run_instr(2, 0, 0, 0, 0, 3'd1, 0);          // link branch
    run_instr(1, 0, 0, 0, 0, 3'd1, 0);          // cond branch not taken
    run_instr(1, 0, 0, 1, 0, 3'd1, 0);          // cond branch taken
    set_waits(2);
    run_instr(4, 0, 0, 0, 1, 3'd2, 0);          // byte store with waits
    set_waits(0); err_idx = 1;
    run_instr(3, 0, 0, 0, 0, 3'd5, 0);          // load bus error
    set_waits(0);
    run_instr(5, 0, 0, 0, 0, 3'd0, 0);          // trap
    set_waits(0); wait_tab[3] = 100;
    run_instr(5, 0, 0, 0, 0, 3'd0, 0);          // vector read timeout -> halt

    // reset while a load is waiting for ack
    set_waits(0); wait_tab[1] = 10;
    instClass_i = 3'd3; irq_i = 1'b0; byteOp_i = 1'b0;
    clr_cnt(); a_idx = 0; req_cnt = 0; held = 1'b0;
    repeat (4) step();
    chk("mid_req", memReq_o, 1);
    do_reset();
    chk("mid_no_regwr", c_rw, 0);

    for (int n = 0; n < 40; n++) begin
      int j;
      foreach (wait_tab[k]) wait_tab[k] = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        j = $urandom_range(0, 4);
        wait_tab[j] = 20;
      end
      err_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr($urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                3'($urandom_range(0, 7)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
